// File: rtl/bus_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions and serializer state encoding.
package bus_uart_pkg;

    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_DIVISOR = 2'd2;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_OVF     = 2;
    localparam int STAT_LVL_LSB = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_e;

endpackage

// File: rtl/bus_uart_fifo.sv
// Transmit byte buffer. With BUS_UART_TX_FIFO_EN defined it is a DEPTH-entry
// circular FIFO; otherwise a single holding register (DEPTH unused).
module bus_uart_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty,
    output logic [7:0] level
);

`ifdef BUS_UART_TX_FIFO_EN
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] lvl;
    logic [7:0]  mem [DEPTH];

    // Pointers carry one extra wrap bit so level = wr - rd distinguishes full from empty
    assign lvl   = wr_ptr - rd_ptr;
    assign full  = (lvl == FULL_LVL);
    assign empty = (lvl == '0);
    assign level = 8'(lvl);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end
`else
    logic       occ;
    logic [7:0] hold;
    logic       unused_depth;

    assign unused_depth = (DEPTH != 0);
    assign dout  = hold;
    assign full  = occ;
    assign empty = !occ;
    assign level = {7'd0, occ};

    always_ff @(posedge clk) begin
        if (rst) begin
            occ <= 1'b0;
        end else if (push && !occ) begin
            occ <= 1'b1;
        end else if (pop && occ) begin
            occ <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !occ) begin
            hold <= din;
        end
    end
`endif

endmodule

// File: rtl/bus_uart_tx.sv
// Bus-attached 8N1 UART transmitter: address decode, TXDATA/STATUS/DIVISOR
// registers and the serializer FSM. Buffer depth selected by BUS_UART_TX_FIFO_EN.
module bus_uart_tx
    import bus_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h10001000,
    parameter logic [15:0] DIV_RESET = 16'd868,
    parameter int          DEPTH     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wren,
    input  logic [3:0]  wmask,
    input  logic [31:0] wdata,
    input  logic [31:0] addr,
    output logic [31:0] rdata,
    output logic        tx
);

    function automatic logic [15:0] eff_div(input logic [15:0] d);
        return (d == 16'd0) ? 16'd1 : d;
    endfunction

    logic        sel;
    logic [1:0]  off;
    logic        wr_tx;
    logic        fifo_push;
    logic        fifo_pop;
    logic [7:0]  fifo_dout;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_level;
    logic        overflow;
    logic [15:0] divisor;
    logic        busy;
    logic [31:0] status_w;
    logic [31:0] rdata_nx;
    logic        unused_bus;

    tx_state_e   state, state_nx;
    logic [15:0] cnt, cnt_nx;
    logic [2:0]  bit_idx, bit_nx;
    logic [7:0]  shreg, sh_nx;
    logic [15:0] div_lat, dl_nx;

    assign sel        = (addr[31:4] == BASE_ADDR[31:4]);
    assign off        = addr[3:2];
    assign wr_tx      = wren && sel && (off == REG_TXDATA) && wmask[0];
    // Full is the pre-edge value, so a write coinciding with a pop still drops
    assign fifo_push  = wr_tx && !fifo_full;
    assign unused_bus = ^{wmask[3:2], wdata[31:16], addr[1:0]};

    bus_uart_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (wdata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
            divisor  <= DIV_RESET;
        end else begin
            if (wr_tx && fifo_full) begin
                overflow <= 1'b1;
            end else if (wren && sel && (off == REG_STATUS) && wmask[0] && wdata[STAT_OVF]) begin
                overflow <= 1'b0;
            end
            if (wren && sel && (off == REG_DIVISOR)) begin
                if (wmask[0]) divisor[7:0]  <= wdata[7:0];
                if (wmask[1]) divisor[15:8] <= wdata[15:8];
            end
        end
    end

    assign busy = (state != ST_IDLE) || !fifo_empty;

    always_comb begin
        status_w                     = '0;
        status_w[STAT_BUSY]          = busy;
        status_w[STAT_FULL]          = fifo_full;
        status_w[STAT_OVF]           = overflow;
        status_w[STAT_LVL_LSB +: 8]  = fifo_level;
    end

    always_comb begin
        rdata_nx = '0;
        if (sel) begin
            unique case (off)
                REG_STATUS:  rdata_nx = status_w;
                REG_DIVISOR: rdata_nx = {16'd0, divisor};
                default:     rdata_nx = '0;
            endcase
        end
    end

    // Read data registered at the edge that samples addr
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else begin
            rdata <= rdata_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            bit_idx <= bit_nx;
        end
    end

    always_ff @(posedge clk) begin
        shreg   <= sh_nx;
        div_lat <= dl_nx;
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        bit_nx   = bit_idx;
        sh_nx    = shreg;
        dl_nx    = div_lat;
        fifo_pop = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    sh_nx    = fifo_dout;
                    dl_nx    = eff_div(divisor);
                    cnt_nx   = eff_div(divisor) - 16'd1;
                    state_nx = ST_START;
                end
            end
            ST_START: begin
                if (cnt == 16'd0) begin
                    cnt_nx   = div_lat - 16'd1;
                    bit_nx   = 3'd0;
                    state_nx = ST_DATA;
                end else begin
                    cnt_nx = cnt - 16'd1;
                end
            end
            ST_DATA: begin
                if (cnt == 16'd0) begin
                    cnt_nx = div_lat - 16'd1;
                    if (bit_idx == 3'd7) begin
                        state_nx = ST_STOP;
                    end else begin
                        bit_nx = bit_idx + 3'd1;
                        sh_nx  = shreg >> 1;
                    end
                end else begin
                    cnt_nx = cnt - 16'd1;
                end
            end
            ST_STOP: begin
                if (cnt != 16'd0) begin
                    cnt_nx = cnt - 16'd1;
                end else if (!fifo_empty) begin
                    // Back-to-back frame: no idle cycle between stop and next start
                    fifo_pop = 1'b1;
                    sh_nx    = fifo_dout;
                    dl_nx    = eff_div(divisor);
                    cnt_nx   = eff_div(divisor) - 16'd1;
                    state_nx = ST_START;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        tx = 1'b1;
        if (state == ST_START) begin
            tx = 1'b0;
        end else if (state == ST_DATA) begin
            tx = shreg[0];
        end
    end

endmodule
